// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM:
// state enum, opcodes, aluOp classes and datapath select encodings.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decode.sv
// Combinational opcode decode: immediate format select plus a legality
// flag that steers the DECODE transition toward TRAP.
module imm_src_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] immSrc,
  output logic       opLegal
);

  always_comb begin
    immSrc  = IMM_I;
    opLegal = 1'b0;
    case (opcode)
      OP_LW:  begin immSrc = IMM_I; opLegal = 1'b1; end
      OP_I:   begin immSrc = IMM_I; opLegal = 1'b1; end
      OP_R:   begin immSrc = IMM_I; opLegal = 1'b1; end
      OP_SW:  begin immSrc = IMM_S; opLegal = 1'b1; end
      OP_BEQ: begin immSrc = IMM_B; opLegal = 1'b1; end
      OP_JAL: begin immSrc = IMM_J; opLegal = 1'b1; end
      default: begin immSrc = IMM_I; opLegal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I main control FSM (lw, sw, R, I, beq, jal) with a
// variable-latency memory handshake. Define RETIRE_CNT_EN to add `instret`.
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       memReady,
  output logic       memReq,
  output logic       memWrite,
  output logic       adrSrc,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       regWrite,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] resultSrc,
  output logic [1:0] immSrc,
  output logic       illegal
`ifdef RETIRE_CNT_EN
  ,
  output logic [31:0] instret
`endif
);

  state_t state;
  state_t next_state;
  logic   op_legal;
  logic   mem_req_raw;
  logic   mem_write_raw;
  logic   ir_write_raw;
  logic   pc_write_raw;
  logic   reg_write_raw;

  imm_src_decode u_imm_src_decode (
    .opcode  (opcode),
    .immSrc  (immSrc),
    .opLegal (op_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = state;
    mem_req_raw   = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    pc_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    adrSrc        = 1'b0;
    aluSrcA       = SRCA_PC;
    aluSrcB       = SRCB_RS2;
    aluOp         = ALUOP_ADD;
    resultSrc     = RES_ALUOUT;
    case (state)
      S_FETCH: begin
        mem_req_raw  = 1'b1;
        aluSrcA      = SRCA_PC;
        aluSrcB      = SRCB_FOUR;
        resultSrc    = RES_ALURESULT;
        ir_write_raw = memReady;
        pc_write_raw = memReady;
        if (memReady) next_state = S_DECODE;
      end
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        if (!op_legal) next_state = S_TRAP;
        else begin
          case (opcode)
            OP_LW, OP_SW: next_state = S_MEMADR;
            OP_R:         next_state = S_EXECR;
            OP_I:         next_state = S_EXECI;
            OP_BEQ:       next_state = S_BEQ;
            OP_JAL:       next_state = S_JAL;
            default:      next_state = S_TRAP;
          endcase
        end
      end
      S_MEMADR: begin
        aluSrcA    = SRCA_RS1;
        aluSrcB    = SRCB_IMM;
        next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_raw = 1'b1;
        adrSrc      = 1'b1;
        if (memReady) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc     = RES_MEMDATA;
        reg_write_raw = 1'b1;
        next_state    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_raw   = 1'b1;
        mem_write_raw = 1'b1;
        adrSrc        = 1'b1;
        if (memReady) next_state = S_FETCH;
      end
      S_EXECR: begin
        aluSrcA    = SRCA_RS1;
        aluSrcB    = SRCB_RS2;
        aluOp      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcA    = SRCA_RS1;
        aluSrcB    = SRCB_IMM;
        aluOp      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        resultSrc     = RES_ALUOUT;
        reg_write_raw = 1'b1;
        next_state    = S_FETCH;
      end
      S_BEQ: begin
        aluSrcA      = SRCA_RS1;
        aluSrcB      = SRCB_RS2;
        aluOp        = ALUOP_SUB;
        resultSrc    = RES_ALUOUT;
        pc_write_raw = zero;
        next_state   = S_FETCH;
      end
      S_JAL: begin
        aluSrcA      = SRCA_OLDPC;
        aluSrcB      = SRCB_FOUR;
        resultSrc    = RES_ALUOUT;
        pc_write_raw = 1'b1;
        next_state   = S_ALUWB;
      end
      S_TRAP: next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

  // Strobes are gated by rst_n so nothing escapes while reset is held,
  // even though the state register already sits in FETCH.
  assign memReq   = mem_req_raw   & rst_n;
  assign memWrite = mem_write_raw & rst_n;
  assign irWrite  = ir_write_raw  & rst_n;
  assign pcWrite  = pc_write_raw  & rst_n;
  assign regWrite = reg_write_raw & rst_n;
  assign illegal  = (state == S_TRAP);

`ifdef RETIRE_CNT_EN
  logic [31:0] instret_q;
  logic        retire;

  assign retire = (next_state == S_FETCH) &&
                  ((state == S_MEMWB) || (state == S_MEMWR) ||
                   (state == S_ALUWB) || (state == S_BEQ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= 32'd0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle output vectors for every
// instruction class, memory waits, reset behaviour, TRAP and optional instret.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       memReady;
  logic       memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, illegal;
  logic [1:0] aluSrcA, aluSrcB, aluOp, resultSrc, immSrc;
`ifdef RETIRE_CNT_EN
  logic [31:0] instret;
`endif

  int checkCount = 0;
  int failCount  = 0;

  multicycle_control dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .zero      (zero),
    .memReady  (memReady),
    .memReq    (memReq),
    .memWrite  (memWrite),
    .adrSrc    (adrSrc),
    .irWrite   (irWrite),
    .pcWrite   (pcWrite),
    .regWrite  (regWrite),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .aluOp     (aluOp),
    .resultSrc (resultSrc),
    .immSrc    (immSrc),
    .illegal   (illegal)
`ifdef RETIRE_CNT_EN
    ,
    .instret   (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: memReq memWrite adrSrc irWrite pcWrite regWrite
  // aluSrcA aluSrcB aluOp resultSrc immSrc illegal
  logic [16:0] obs;
  assign obs = {memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite,
                aluSrcA, aluSrcB, aluOp, resultSrc, immSrc, illegal};

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  function automatic logic [16:0] vec(input logic mr, mw, as, ir, pw, rw,
                                      input logic [1:0] sa, sb, op, rs, im,
                                      input logic il);
    return {mr, mw, as, ir, pw, rw, sa, sb, op, rs, im, il};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, advance to next negedge.
  task automatic applyStimulus(input string tag, input logic [6:0] opc,
                               input logic ready, input logic z,
                               input logic [16:0] expected);
    opcode   = opc;
    memReady = ready;
    zero     = z;
    #1;
    checkOutput(tag, {15'd0, obs}, {15'd0, expected});
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; opcode = 7'd0; zero = 1'b0; memReady = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("reset_vec", {15'd0, obs}, {15'd0, vec(0,0,0,0,0,0,2'd0,2'd2,2'd0,2'd2,2'd0,0)});
    @(negedge clk);
    rst_n = 1'b1;

    // add
    applyStimulus("add_fetch",  RT, 1, 0, vec(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,2'd0,0));
    applyStimulus("add_decode", RT, 1, 0, vec(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,2'd0,0));
    applyStimulus("add_execr",  RT, 1, 0, vec(0,0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,2'd0,0));
    applyStimulus("add_aluwb",  RT, 1, 0, vec(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,2'd0,0));

    // lw with one FETCH wait and two MEMRD waits
    applyStimulus("lw_fetch_wait", LW, 0, 0, vec(1,0,0,0,0,0,2'd0,2'd2,2'd0,2'd2,2'd0,0));
    applyStimulus("lw_fetch",      LW, 1, 0, vec(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,2'd0,0));
    applyStimulus("lw_decode",     LW, 1, 0, vec(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,2'd0,0));
    applyStimulus("lw_memadr",     LW, 1, 0, vec(0,0,0,0,0,0,2'd2,2'd1,2'd0,2'd0,2'd0,0));
    applyStimulus("lw_memrd_w1",   LW, 0, 0, vec(1,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0,0));
    applyStimulus("lw_memrd_w2",   LW, 0, 0, vec(1,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0,0));
    applyStimulus("lw_memrd",      LW, 1, 0, vec(1,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0,0));
    applyStimulus("lw_memwb",      LW, 1, 0, vec(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd1,2'd0,0));

    // sw with one MEMWR wait
    applyStimulus("sw_fetch",   SW, 1, 0, vec(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,2'd1,0));
    applyStimulus("sw_decode",  SW, 1, 0, vec(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,2'd1,0));
    applyStimulus("sw_memadr",  SW, 1, 0, vec(0,0,0,0,0,0,2'd2,2'd1,2'd0,2'd0,2'd1,0));
    applyStimulus("sw_memwr_w", SW, 0, 0, vec(1,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd1,0));
    applyStimulus("sw_memwr",   SW, 1, 0, vec(1,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd1,0));

    // addi
    applyStimulus("addi_fetch",  IT, 1, 0, vec(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,2'd0,0));
    applyStimulus("addi_decode", IT, 1, 0, vec(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,2'd0,0));
    applyStimulus("addi_execi",  IT, 1, 0, vec(0,0,0,0,0,0,2'd2,2'd1,2'd2,2'd0,2'd0,0));
    applyStimulus("addi_aluwb",  IT, 1, 0, vec(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,2'd0,0));

    // beq taken, then not taken
    applyStimulus("beq1_fetch",  BQ, 1, 0, vec(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,2'd2,0));
    applyStimulus("beq1_decode", BQ, 1, 1, vec(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,2'd2,0));
    applyStimulus("beq1_beq",    BQ, 1, 1, vec(0,0,0,0,1,0,2'd2,2'd0,2'd1,2'd0,2'd2,0));
    applyStimulus("beq0_fetch",  BQ, 1, 0, vec(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,2'd2,0));
    applyStimulus("beq0_decode", BQ, 1, 0, vec(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,2'd2,0));
    applyStimulus("beq0_beq",    BQ, 1, 0, vec(0,0,0,0,0,0,2'd2,2'd0,2'd1,2'd0,2'd2,0));

    // jal
    applyStimulus("jal_fetch",  JL, 1, 0, vec(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,2'd3,0));
    applyStimulus("jal_decode", JL, 1, 0, vec(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,2'd3,0));
    applyStimulus("jal_jal",    JL, 1, 0, vec(0,0,0,0,1,0,2'd1,2'd2,2'd0,2'd0,2'd3,0));
    applyStimulus("jal_aluwb",  JL, 1, 0, vec(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,2'd3,0));
`ifdef RETIRE_CNT_EN
    #1;
    checkOutput("instret_seven", instret, 32'd7);
    @(negedge clk);
`endif

    // Reset asserted mid-store drops every strobe immediately
    applyStimulus("sw2_fetch",  SW, 1, 0, vec(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,2'd1,0));
    applyStimulus("sw2_decode", SW, 1, 0, vec(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,2'd1,0));
    applyStimulus("sw2_memadr", SW, 1, 0, vec(0,0,0,0,0,0,2'd2,2'd1,2'd0,2'd0,2'd1,0));
    memReady = 1'b0;
    #1;
    checkOutput("sw2_memwr_w", {15'd0, obs}, {15'd0, vec(1,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd1,0)});
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_vec", {15'd0, obs}, {15'd0, vec(0,0,0,0,0,0,2'd0,2'd2,2'd0,2'd2,2'd1,0)});
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_midreset_fetch", SW, 0, 0, vec(1,0,0,0,0,0,2'd0,2'd2,2'd0,2'd2,2'd1,0));

    // Illegal opcode lands in TRAP and stays there
    applyStimulus("trap_fetch",  7'd0, 1, 0, vec(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,2'd0,0));
    applyStimulus("trap_decode", 7'd0, 1, 0, vec(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,2'd0,0));
    for (int i = 0; i < 3; i++)
      applyStimulus("trap_hold", RT, 1, 1, vec(0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0,1));
    rst_n = 1'b0;
    #1;
    checkOutput("trap_reset_illegal", {31'd0, illegal}, 32'd0);
    checkOutput("trap_reset_memreq",  {31'd0, memReq},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef RETIRE_CNT_EN
    checkOutput("instret_reset", instret, 32'd0);
    applyStimulus("rc_sw_f",  SW, 1, 0, vec(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,2'd1,0));
    applyStimulus("rc_sw_d",  SW, 1, 0, vec(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,2'd1,0));
    applyStimulus("rc_sw_a",  SW, 1, 0, vec(0,0,0,0,0,0,2'd2,2'd1,2'd0,2'd0,2'd1,0));
    applyStimulus("rc_sw_w",  SW, 1, 0, vec(1,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd1,0));
    applyStimulus("rc_jal_f", JL, 1, 0, vec(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,2'd3,0));
    applyStimulus("rc_jal_d", JL, 1, 0, vec(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,2'd3,0));
    applyStimulus("rc_jal_j", JL, 1, 0, vec(0,0,0,0,1,0,2'd1,2'd2,2'd0,2'd0,2'd3,0));
    applyStimulus("rc_jal_w", JL, 1, 0, vec(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,2'd3,0));
    applyStimulus("rc_add_f", RT, 1, 0, vec(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,2'd0,0));
    applyStimulus("rc_add_d", RT, 1, 0, vec(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,2'd0,0));
    applyStimulus("rc_add_e", RT, 1, 0, vec(0,0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,2'd0,0));
    applyStimulus("rc_add_w", RT, 1, 0, vec(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,2'd0,0));
    #1;
    checkOutput("instret_three", instret, 32'd3);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    @(negedge clk);
    applyStimulus("rc_beq_f", BQ, 1, 0, vec(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,2'd2,0));
    applyStimulus("rc_beq_d", BQ, 1, 0, vec(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,2'd2,0));
    applyStimulus("rc_beq_b", BQ, 1, 0, vec(0,0,0,0,0,0,2'd2,2'd0,2'd1,2'd0,2'd2,0));
    #1;
    checkOutput("instret_wrap", instret, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
